// File: rtl/wishbone_arbiter_2m_pkg.sv
// rtl/wishbone_arbiter_2m_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wishbone_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;

  // Counter width able to hold the value limit itself (the saturation point).
  function automatic int hold_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wishbone_arbiter_2m_if.sv
// rtl/wishbone_arbiter_2m_if.sv - Wishbone B4 classic/registered-feedback bus bundle
interface wishbone_arbiter_2m_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   dat_w;
  logic [DATA_W/8-1:0] sel;
  logic                we;
  logic                cyc;
  logic                stb;
  logic [2:0]          cti;
  logic [1:0]          bte;
  logic                ack;
  logic [DATA_W-1:0]   dat_r;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  ack, dat_r
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output ack, dat_r
  );

endinterface

// File: rtl/wishbone_hold_timer.sv
// rtl/wishbone_hold_timer.sv - saturating idle-ownership counter with preemption compare
module wishbone_hold_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] limit_m1;

  assign limit_m1 = limit_i - CNT_W'(1);

  // Expiry is qualified by count_en so it lands on the idle cycle that would reach the limit.
  assign expire_o = count_en_i && (cnt_q == limit_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// rtl/wishbone_arbiter_2m.sv - two-master round-robin Wishbone arbiter with hold-limit preemption
module wishbone_arbiter_2m
  import wishbone_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int HOLD_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wishbone_arbiter_2m_if.slave  m0,
  wishbone_arbiter_2m_if.slave  m1,
  wishbone_arbiter_2m_if.master s,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  preempt_pulse
);

  localparam int CNT_W = hold_cnt_width(HOLD_LIMIT);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // 1 when m1 was the most recent owner
  logic       blk0_q, blk0_d;
  logic       blk1_q, blk1_d;
  logic       el0, el1;
  logic       count_en;
  logic       expire;

  logic [ADDR_W-1:0]   adr_mux;
  logic [DATA_W-1:0]   dat_w_mux;
  logic [DATA_W/8-1:0] sel_mux;
  logic                we_mux;
  logic                cyc_mux;
  logic                stb_mux;
  logic [2:0]          cti_mux;
  logic [1:0]          bte_mux;

  assign el0 = m0.cyc & ~blk0_q;
  assign el1 = m1.cyc & ~blk1_q;

  assign count_en = ((state_q == OWN0) & m0.cyc & ~m0.stb & el1)
                  | ((state_q == OWN1) & m1.cyc & ~m1.stb & el0);

  wishbone_hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en_i (count_en),
    .clear_i    (~count_en | expire),
    .limit_i    (CNT_W'(HOLD_LIMIT)),
    .expire_o   (expire)
  );

  assign preempt_pulse = expire;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    // A block survives only while the preempted master keeps cyc asserted.
    blk0_d  = blk0_q & m0.cyc;
    blk1_d  = blk1_q & m1.cyc;
    case (state_q)
      IDLE: begin
        if (el0 && el1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (el0) begin
          state_d = OWN0;
        end else if (el1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0.cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (expire) begin
          state_d = IDLE;
          last_d  = 1'b0;
          blk0_d  = 1'b1;
        end
      end
      OWN1: begin
        if (!m1.cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          last_d  = 1'b1;
          blk1_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      blk0_q  <= 1'b0;
      blk1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      blk0_q  <= blk0_d;
      blk1_q  <= blk1_d;
    end
  end

  // Idle bus parks address/data on m0 but never presents a live cycle.
  always_comb begin
    adr_mux   = m0.adr;
    dat_w_mux = m0.dat_w;
    sel_mux   = m0.sel;
    bte_mux   = m0.bte;
    cti_mux   = WB_CTI_CLASSIC;
    we_mux    = 1'b0;
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    case (state_q)
      OWN0: begin
        cti_mux = m0.cti;
        we_mux  = m0.we;
        cyc_mux = m0.cyc;
        stb_mux = m0.stb;
      end
      OWN1: begin
        adr_mux   = m1.adr;
        dat_w_mux = m1.dat_w;
        sel_mux   = m1.sel;
        bte_mux   = m1.bte;
        cti_mux   = m1.cti;
        we_mux    = m1.we;
        cyc_mux   = m1.cyc;
        stb_mux   = m1.stb;
      end
      default: ;
    endcase
  end

  assign s.adr   = adr_mux;
  assign s.dat_w = dat_w_mux;
  assign s.sel   = sel_mux;
  assign s.we    = we_mux;
  assign s.cyc   = cyc_mux;
  assign s.stb   = stb_mux;
  assign s.cti   = cti_mux;
  assign s.bte   = bte_mux;

  assign m0_gnt   = (state_q == OWN0);
  assign m1_gnt   = (state_q == OWN1);
  assign m0.ack   = s.ack & m0_gnt;
  assign m1.ack   = s.ack & m1_gnt;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// tb/tb_wishbone_arbiter_2m.sv - self-checking bench for wishbone_arbiter_2m
module tb_wishbone_arbiter_2m;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_gnt, m1_gnt, preempt_pulse;
  int   pass_cnt  = 0;
  int   check_cnt = 0;

  wishbone_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  wishbone_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  wishbone_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  wishbone_arbiter_2m #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .HOLD_LIMIT (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .m0_gnt        (m0_gnt),
    .m1_gnt        (m1_gnt),
    .preempt_pulse (preempt_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Columns: c0 s0 c1 s1 s_ack | g0 g1 s_cyc s_stb s_we a0 a1 | s_adr
  typedef struct packed {
    logic c0, s0, c1, s1, ack;
    logic g0, g1, scyc, sstb, swe, a0, a1;
    logic [31:0] sadr;
  } vec_t;
  vec_t vt [16];
  vec_t v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drv(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.adr = adr;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.adr = adr;
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Read by master m: waits (bounded) for the grant, slave acks two cycles after the grant.
  task automatic rd(input int m, input logic [31:0] adr, input logic [31:0] data,
                    input int glat, input bit keep);
    int n = 0;
    drv(m, 1'b1, 1'b1, adr);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if ((m == 0) ? m0_gnt : m1_gnt) break;
      n++;
      nxt();
    end
    chk("grant_latency", n, glat);
    nxt();
    nxt();
    s_if.ack = 1'b1;
    s_if.dat_r = data;
    sb.push_back('{id: (m != 0), data: data});
    @(negedge clk);
    chk("other_ack_quiet", (m == 0) ? m1_if.ack : m0_if.ack, 1'b0);
    nxt();
    s_if.ack = 1'b0;
    drv(m, keep, 1'b0, adr);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (m0_if.ack || m1_if.ack)) begin
      if (sb.size() == 0) begin
        chk("sb_spurious_ack", {m0_if.ack, m1_if.ack}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_ack_owner", {m0_if.ack, m1_if.ack}, mon_e.id ? 2'b01 : 2'b10);
        chk("sb_dat_r", m1_if.ack ? m1_if.dat_r : m0_if.dat_r, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = {5'b00001, 7'b0000000, 32'h100};
    vt[1]  = {5'b11110, 7'b0000000, 32'h100};
    vt[2]  = {5'b11110, 7'b1011000, 32'h100};
    vt[3]  = {5'b11111, 7'b1011010, 32'h100};
    vt[4]  = {5'b00110, 7'b1000000, 32'h100};
    vt[5]  = {5'b00110, 7'b0000000, 32'h100};
    vt[6]  = {5'b00110, 7'b0111100, 32'h200};
    vt[7]  = {5'b00111, 7'b0111101, 32'h200};
    vt[8]  = {5'b11000, 7'b0100100, 32'h200};
    vt[9]  = {5'b11110, 7'b0000000, 32'h100};
    vt[10] = {5'b11111, 7'b1011010, 32'h100};
    vt[11] = {5'b00000, 7'b1000000, 32'h100};
    vt[12] = {5'b10100, 7'b0000000, 32'h100};
    vt[13] = {5'b10100, 7'b0110100, 32'h200};
    vt[14] = {5'b00001, 7'b0100101, 32'h200};
    vt[15] = {5'b00001, 7'b0000000, 32'h100};

    rst_n = 1'b0;
    m0_if.adr = 32'h100; m0_if.dat_w = 32'h0; m0_if.sel = 4'hF; m0_if.we = 1'b0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.cti = 3'b000; m0_if.bte = 2'b00;
    m1_if.adr = 32'h200; m1_if.dat_w = 32'h0; m1_if.sel = 4'hF; m1_if.we = 1'b1;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.cti = 3'b000; m1_if.bte = 2'b00;
    s_if.ack = 1'b1; s_if.dat_r = 32'h0;

    #3;
    chk("rst_s_cyc", s_if.cyc, 1'b0);
    chk("rst_s_stb", s_if.stb, 1'b0);
    chk("rst_s_we", s_if.we, 1'b0);
    chk("rst_acks", {m0_if.ack, m1_if.ack}, 2'b00);
    chk("rst_gnts", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_preempt", preempt_pulse, 1'b0);
    nxt();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      v = vt[i];
      drv(0, v.c0, v.s0, 32'h100);
      drv(1, v.c1, v.s1, 32'h200);
      s_if.ack = v.ack;
      s_if.dat_r = 32'hC0DE_0000 + 32'(i);
      if (v.a0) sb.push_back('{id: 1'b0, data: s_if.dat_r});
      if (v.a1) sb.push_back('{id: 1'b1, data: s_if.dat_r});
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {m0_gnt, m1_gnt}, {v.g0, v.g1});
      chk($sformatf("v%0d_s_cyc_stb_we", i), {s_if.cyc, s_if.stb, s_if.we}, {v.scyc, v.sstb, v.swe});
      chk($sformatf("v%0d_acks", i), {m0_if.ack, m1_if.ack}, {v.a0, v.a1});
      chk($sformatf("v%0d_s_adr", i), s_if.adr, v.sadr);
      chk($sformatf("v%0d_dat_r_fanout", i), {m0_if.dat_r, m1_if.dat_r}, {2{32'hC0DE_0000 + 32'(i)}});
      chk($sformatf("v%0d_preempt", i), preempt_pulse, 1'b0);
      nxt();
    end
    s_if.ack = 1'b0;
    m1_if.we = 1'b0;

    // Single master read
    rd(0, 32'h0000_1000, 32'hDEAD_BEEF, 1, 1'b0);
    repeat (2) nxt();

    // m0 holds cyc idle for 10 cycles; m1 must wait
    rd(0, 32'h0000_2000, 32'h1234_5678, 1, 1'b1);
    drv(1, 1'b1, 1'b1, 32'h2200);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_gnt", k), {m0_gnt, m1_gnt}, 2'b10);
      chk($sformatf("hold%0d_s_cyc", k), s_if.cyc, 1'b1);
      nxt();
    end
    drv(0, 1'b0, 1'b0, 32'h2000);
    rd(1, 32'h2200, 32'h1111_2222, 2, 1'b0);
    repeat (2) nxt();

    // Preemption at idle cycle 64
    rd(0, 32'h0000_3000, 32'h3333_4444, 1, 1'b1);
    drv(1, 1'b1, 1'b1, 32'h4000);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk($sformatf("pre%0d_pulse", k), preempt_pulse, (k == 64));
      chk($sformatf("pre%0d_m1_gnt", k), m1_gnt, 1'b0);
      nxt();
    end
    drv(0, 1'b1, 1'b1, 32'h3000);
    @(negedge clk);
    chk("post_pre_idle_gnt", {m0_gnt, m1_gnt, s_if.cyc, preempt_pulse}, 4'b0000);
    nxt();
    rd(1, 32'h4000, 32'h5555_6666, 0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("blocked%0d_m0_gnt", k), m0_gnt, 1'b0);
      nxt();
    end
    drv(0, 1'b0, 1'b0, 32'h3000);
    nxt();
    rd(0, 32'h4400, 32'h7777_8888, 1, 1'b0);
    repeat (2) nxt();

    // Strobe at idle cycle 64 restarts the count
    rd(0, 32'h0000_5000, 32'h9999_AAAA, 1, 1'b1);
    drv(1, 1'b1, 1'b1, 32'h6000);
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      chk($sformatf("stb_a%0d_pulse", k), preempt_pulse, 1'b0);
      nxt();
    end
    m0_if.stb = 1'b1;
    @(negedge clk);
    chk("stb_hit_pulse", {preempt_pulse, m0_gnt}, 2'b01);
    nxt();
    m0_if.stb = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk($sformatf("stb_b%0d_pulse", k), preempt_pulse, (k == 64));
      nxt();
    end
    drv(0, 1'b0, 1'b0, 32'h5000);
    rd(1, 32'h6000, 32'hBBBB_CCCC, 1, 1'b0);
    repeat (2) nxt();

    // Async reset during an m1 write
    drv(1, 1'b1, 1'b1, 32'h7000);
    m1_if.we = 1'b1;
    nxt();
    @(negedge clk);
    chk("wr_own1", {m1_gnt, s_if.cyc, s_if.stb, s_if.we}, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {m0_gnt, m1_gnt, s_if.cyc, s_if.stb, s_if.we}, 5'b00000);
    drv(1, 1'b0, 1'b0, 32'h7000);
    m1_if.we = 1'b0;
    repeat (2) nxt();
    rst_n = 1'b1;
    drv(0, 1'b1, 1'b1, 32'h100);
    drv(1, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    chk("rst_tie_idle", {m0_gnt, m1_gnt}, 2'b00);
    nxt();
    @(negedge clk);
    chk("rst_tie_m0_first", {m0_gnt, m1_gnt}, 2'b10);
    nxt();
    drv(0, 1'b0, 1'b0, 32'h100);
    drv(1, 1'b0, 1'b0, 32'h200);
    repeat (3) nxt();

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
